// File: rtl/sm_hex_display_mux.sv
// Time-multiplexed hex display driver.
// Takes DIGITS hex nibbles plus per-digit decimal points and decodes them to seven-segment
// patterns. It scans one digit per slot onto a shared segment bus.
// Inputs are captured once per frame, so a frame never mixes old and new values.
// Optional leading-zero blanking, 16-level brightness PWM and a guard gap at the start of
// each slot suppress ghosting between digits.
// Internal logic is active-high; polarity inversion happens only at the output registers.

`timescale 1ns / 1ps

module sm_hex_display_mux #(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned DIV_LOG2       = 5,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clkIn,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzb_en,
  input  logic                  display_en,
  input  logic [3:0]            brightness,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IdxW-1:0]     IdxLast = IdxW'(DIGITS - 1);
  localparam logic [DIV_LOG2-1:0] CntLast = {DIV_LOG2{1'b1}};
  localparam logic [DIV_LOG2-1:0] Guard   = DIV_LOG2'(GUARD);

  // Inactive output levels, also used as reset values.
  localparam logic [7:0]        SegOff = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SelOff = {DIGITS{SEL_ACTIVE_LOW}};

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] seg;
    unique case (val)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Scan state.
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                slot_end;
  logic                frame_load;

  // Frame snapshot.
  logic [4*DIGITS-1:0] snap_digits_q;
  logic [DIGITS-1:0]   snap_dp_q;

  // Decode path.
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_digit;
  logic                cur_dp;
  logic                cur_blank;
  logic                on_window;
  logic [7:0]          seg_act;
  logic [DIGITS-1:0]   sel_act;

  // Output registers.
  logic [7:0]          segments_q;
  logic [DIGITS-1:0]   digit_sel_q;
  logic                frame_start_q;

  assign slot_end   = (cnt_q == CntLast);
  assign frame_load = slot_end && (idx_q == IdxLast);

  // Next slot counter and digit index; idx advances only on the last cycle of a slot.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      if (idx_q == IdxLast) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Scan counter and digit index registers.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Capture inputs only at the end of the last slot so the next frame is tear-free.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
    end else if (frame_load) begin
      snap_digits_q <= digits_in;
      snap_dp_q     <= dp_in;
    end
  end

  // Leading-zero blanking: walk from the top digit down while every digit seen is zero.
  // lzb_en is applied live, not snapshotted.
  always_comb begin
    logic zero_run;
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run && (snap_digits_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        blank_vec[i] = lzb_en && zero_run;
      end
    end
  end

  // Select the snapshot nibble, dp and blank flag for the digit currently being scanned.
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit = snap_digits_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
        cur_blank = blank_vec[i];
      end
    end
  end

  // On window: past the guard gap and within the PWM duty set by the top 4 counter bits.
  always_comb begin
    on_window = display_en
             && (cnt_q >= Guard)
             && (cnt_q[DIV_LOG2-1 -: 4] <= brightness);
  end

  // Active-high segment and select values for this cycle; everything dark outside the window.
  always_comb begin
    seg_act = 8'h00;
    sel_act = '0;
    if (on_window) begin
      seg_act = {cur_dp, (cur_blank ? 7'h00 : hex_to_seg(cur_digit))};
      for (int i = 0; i < int'(DIGITS); i++) begin
        sel_act[i] = (idx_q == IdxW'(i));
      end
    end
  end

  // Output registers with polarity applied; reset drives everything inactive asynchronously.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      segments_q    <= SegOff;
      digit_sel_q   <= SelOff;
      frame_start_q <= 1'b0;
    end else begin
      segments_q    <= seg_act ^ SegOff;
      digit_sel_q   <= sel_act ^ SelOff;
      frame_start_q <= frame_load;
    end
  end

  assign segments    = segments_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// Scoreboard bench for sm_hex_display_mux with default parameters.
// The stimulus process pushes the expected output for each cycle from a cycle-count model.
// A separate monitor pops and compares on the falling edge.

`timescale 1ns / 1ps

module tb_sm_hex_display_mux;

  localparam int DIGITS   = 3;
  localparam int DIV_LOG2 = 5;
  localparam int GUARD    = 2;
  localparam int S        = 1 << DIV_LOG2;  // slot length
  localparam int F        = DIGITS * S;     // frame length

  logic                clkIn = 1'b0;
  logic                rst;
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic                lzb_en;
  logic                display_en;
  logic [3:0]          brightness;
  logic [7:0]          segments;
  logic [DIGITS-1:0]   digit_sel;
  logic                frame_start;

  sm_hex_display_mux #(
    .DIGITS         (DIGITS),
    .DIV_LOG2       (DIV_LOG2),
    .GUARD          (GUARD),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clkIn       (clkIn),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .lzb_en      (lzb_en),
    .display_en  (display_en),
    .brightness  (brightness),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic [7:0]        seg;
    logic [DIGITS-1:0] sel;
    logic              fs;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  int k;           // clock edges since reset release; DUT state belongs to cycle k
  int snap_digits; // model snapshot
  int snap_dp;

  int hex_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs in cycle j+1, from the scan position of cycle j and inputs live in cycle j.
  task automatic push_expected(input int j);
    exp_t e;
    int   cnt, idx, digit, segs;
    bit   on, blank;
    cnt   = j % S;
    idx   = (j / S) % DIGITS;
    on    = display_en && (cnt >= GUARD) && ((cnt / (S / 16)) <= int'(brightness));
    digit = (snap_digits >> (4 * idx)) & 15;
    // Digits idx and above all zero exactly when the shifted snapshot is zero.
    blank = lzb_en && (idx > 0) && ((snap_digits >> (4 * idx)) == 0);
    segs  = 0;
    if (on) segs = (((snap_dp >> idx) & 1) << 7) | (blank ? 0 : hex_tab[digit]);
    e.seg = 8'((segs ^ 'hFF) & 'hFF);
    e.sel = on ? DIGITS'(~(1 << idx)) : {DIGITS{1'b1}};
    e.fs  = ((j % F) == F - 1);
    e.cyc = j + 1;
    exp_q.push_back(e);
    if ((j % F) == F - 1) begin
      snap_digits = int'(digits_in);
      snap_dp     = int'(dp_in);
    end
  endtask

  // Advance n cycles; mode 1 randomises the inputs every cycle.
  task automatic run_cycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(posedge clkIn);
      k++;
      #1;
      push_expected(k - 1);
      if (mode == 1) begin
        if ($urandom_range(0, 15) == 0) begin
          for (int d = 0; d < DIGITS; d++)
            digits_in[4*d +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
          dp_in = DIGITS'($urandom_range(0, (1 << DIGITS) - 1));
        end
        if ($urandom_range(0, 63) == 0) lzb_en = ~lzb_en;
        if ($urandom_range(0, 39) == 0) brightness = 4'($urandom_range(0, 15));
        display_en = ($urandom_range(0, 19) != 0);
      end
    end
  endtask

  // Monitor: compare the registered outputs against the scoreboard away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clkIn);
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("segments", e.cyc, 32'(segments), 32'(e.seg));
        check("digit_sel", e.cyc, 32'(digit_sel), 32'(e.sel));
        check("frame_start", e.cyc, 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin
    bit found;
    rst        = 1'b1;
    digits_in  = '0;
    dp_in      = '0;
    lzb_en     = 1'b0;
    display_en = 1'b1;
    brightness = 4'd15;
    snap_digits = 0;
    snap_dp     = 0;
    k           = 0;

    #8;
    check("reset_segments", 0, 32'(segments), 32'hFF);
    check("reset_digit_sel", 0, 32'(digit_sel), 32'h7);
    check("reset_frame_start", 0, 32'(frame_start), 32'h0);
    #4;
    rst    = 1'b0;  // released between edges; cycle 0 starts here
    mon_en = 1'b1;

    // Zeros, no blanking, full brightness.
    run_cycles(2 * F, 0);
    // 0A5 with dp on digit 1 and blanking.
    digits_in = 12'h0A5;
    dp_in     = 3'b010;
    lzb_en    = 1'b1;
    run_cycles(3 * F, 0);
    // All zeros with blanking; change inputs mid-frame, which must not show until the snapshot.
    digits_in = 12'h000;
    dp_in     = 3'b000;
    run_cycles(F + S + 5, 0);
    digits_in = 12'h7E3;
    run_cycles(2 * F, 0);
    // Brightness and enable.
    brightness = 4'd3;
    run_cycles(2 * F, 0);
    brightness = 4'd0;
    run_cycles(F, 0);
    display_en = 1'b0;
    run_cycles(F, 0);
    display_en = 1'b1;
    brightness = 4'd15;

    run_cycles(2000, 1);

    // Asynchronous reset at cnt 17, idx 2.
    found = 1'b0;
    for (int t = 0; t < 2 * F && !found; t++) begin
      run_cycles(1, 0);
      if ((k % S) == 17 && ((k / S) % DIGITS) == 2) found = 1'b1;
    end
    check("reset_point_reached", k, 32'(found), 32'h1);
    display_en = 1'b1;
    brightness = 4'd15;
    mon_en     = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_segments", k, 32'(segments), 32'hFF);
    check("async_rst_digit_sel", k, 32'(digit_sel), 32'h7);
    check("async_rst_frame_start", k, 32'(frame_start), 32'h0);
    @(posedge clkIn);
    @(negedge clkIn);
    check("rst_hold_digit_sel", k, 32'(digit_sel), 32'h7);
    exp_q.delete();
    #2;
    rst         = 1'b0;
    k           = 0;
    snap_digits = 0;
    snap_dp     = 0;
    mon_en      = 1'b1;

    run_cycles(F + 10, 0);
    run_cycles(400, 1);
    @(negedge clkIn);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
